// File: rtl/l1c_arb_pkg.sv
// Shared types and constants for the L1 instruction/data cache memory-port arbiter.
package l1c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int LINE_BEATS = 4;

endpackage

// File: rtl/l1c_arb_beat_ctr.sv
// Two-bit beat counter for line fills; clear has priority over increment.
module l1c_arb_beat_ctr
  import l1c_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o,
  output logic       last_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == 2'(LINE_BEATS - 1));

endmodule

// File: rtl/l1c_mem_arbiter.sv
// Whole-transaction arbiter sharing one memory port between the L1 I-cache and D-cache.
// Define L1C_ARB_RR_EN for round-robin tie-breaking; otherwise D has fixed priority over I.
module l1c_mem_arbiter
  import l1c_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_in,
  input  logic [TYPE_W-1:0] i_type,
  output logic [DATA_W-1:0] i_out,
  output logic              i_wait,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_in,
  input  logic [TYPE_W-1:0] d_type,
  output logic [DATA_W-1:0] d_out,
  output logic              d_wait,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [DATA_W-1:0] m_in,
  output logic [TYPE_W-1:0] m_type,
  input  logic [DATA_W-1:0] m_out,
  input  logic              m_wait,
  output logic [1:0]        dbg_state_o,
  output logic [1:0]        dbg_beat_cnt_o,
  output logic              dbg_last_grant_o
);

  // Handshake: a requester holds req (and its address/data) for the whole transaction;
  // a beat transfers on any cycle with m_req & ~m_wait, and the owner sees wait = m_wait.

  arb_state_t state_q;
  arb_state_t state_d;
  logic       owner_req;
  logic       owner_write;
  logic       accept;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_last;
  logic [1:0] beat_cnt;
  logic       tie_to_d;

`ifdef L1C_ARB_RR_EN
  owner_t last_grant_q;
  owner_t last_grant_d;

  assign tie_to_d = (last_grant_q == OWN_I);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && state_d == GNT_D) begin
      last_grant_d = OWN_D;
    end else if (state_q == IDLE && state_d == GNT_I) begin
      last_grant_d = OWN_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWN_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign dbg_last_grant_o = last_grant_q;
`else
  assign tie_to_d         = 1'b1;
  assign dbg_last_grant_o = OWN_I;
`endif

  l1c_arb_beat_ctr u_beat_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (beat_cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_write = 1'b0;
    m_in    = '0;
    m_type  = '0;
    i_out   = '0;
    d_out   = '0;
    i_wait  = i_req;
    d_wait  = d_req;
    case (state_q)
      GNT_I: begin
        m_req   = i_req;
        m_addr  = i_addr;
        m_write = i_write;
        m_in    = i_in;
        m_type  = i_type;
        i_out   = m_out;
        i_wait  = m_wait;
        d_wait  = 1'b1;
      end
      GNT_D: begin
        m_req   = d_req;
        m_addr  = d_addr;
        m_write = d_write;
        m_in    = d_in;
        m_type  = d_type;
        d_out   = m_out;
        d_wait  = m_wait;
        i_wait  = 1'b1;
      end
      default: ;
    endcase
  end

  assign owner_req   = (state_q == GNT_I) ? i_req   : d_req;
  assign owner_write = (state_q == GNT_I) ? i_write : d_write;
  assign accept      = m_req & ~m_wait;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (i_req && d_req) begin
          state_d = tie_to_d ? GNT_D : GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end else if (i_req) begin
          state_d = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        // Owner dropping req mid-transaction aborts without issuing another beat.
        if (!owner_req) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (accept) begin
          if (owner_write || cnt_last) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt;

endmodule
